// File: rtl/alu_md_decoder.sv
// rtl/alu_md_decoder.sv - ALU control decoder with iterative multiply/divide unit and HI/LO
// One radix-2 step per cycle; stall holds the issuing instruction until HI/LO are written.
module alu_md_decoder #(
   parameter int WIDTH  = 32,
   parameter bit EN_DIV = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [2:0]       ALUControl,
   output logic             md_sel,
   output logic [WIDTH-1:0] md_result,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam int         CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH:0]   r_p;
   logic [WIDTH-1:0]   r_b_mag, r_a_raw;
   logic               r_div, r_neg_q, r_neg_r, r_b_zero;

   logic               w_is_mdu, w_is_mult, w_is_div, w_start, w_signed;
   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH:0]   w_shl, w_p_step;
   logic [2*WIDTH-1:0] w_prod;

   always_comb begin
      ALUControl = 3'b010;
      case (ALUOp)
         2'b01: ALUControl = 3'b100;
         2'b10: begin
            case (Funct)
               6'b100010: ALUControl = 3'b100;
               6'b101010: ALUControl = 3'b110;
               6'b011100: ALUControl = 3'b101;
               6'b100100: ALUControl = 3'b000;
               6'b100101: ALUControl = 3'b001;
               default:   ALUControl = 3'b010;
            endcase
         end
         default: ALUControl = 3'b010;
      endcase
   end

   assign w_is_mdu  = valid_i && (ALUOp == 2'b10);
   assign w_is_mult = w_is_mdu && (Funct == F_MULT || Funct == F_MULTU);
   assign w_is_div  = EN_DIV && w_is_mdu && (Funct == F_DIV || Funct == F_DIVU);
   assign w_start   = (r_state == S_IDLE) && (w_is_mult || w_is_div);
   assign w_signed  = (Funct == F_MULT) || (Funct == F_DIV);
   assign w_a_neg   = w_signed && src_a[WIDTH-1];
   assign w_b_neg   = w_signed && src_b[WIDTH-1];
   assign w_a_mag   = w_a_neg ? -src_a : src_a;
   assign w_b_mag   = w_b_neg ? -src_b : src_b;

   assign md_sel    = w_is_mdu && (Funct == F_MFHI || Funct == F_MFLO);
   assign md_result = !md_sel ? '0 : (Funct == F_MFHI) ? hi : lo;

   // Multiply and divide share r_p: low half starts as |a|, upper W+1 bits accumulate.
   always_comb begin
      w_sum    = r_p[2*WIDTH:WIDTH] + (r_p[0] ? {1'b0, r_b_mag} : '0);
      w_shl    = r_p << 1;
      w_p_step = w_shl;
      if (r_div) begin
         if (w_shl[2*WIDTH:WIDTH] >= {1'b0, r_b_mag})
            w_p_step = {w_shl[2*WIDTH:WIDTH] - {1'b0, r_b_mag}, w_shl[WIDTH-1:1], 1'b1};
      end else begin
         w_p_step = {1'b0, w_sum, r_p[WIDTH-1:1]};
      end
      w_prod = r_neg_q ? -w_p_step[2*WIDTH-1:0] : w_p_step[2*WIDTH-1:0];
      w_quo  = w_p_step[WIDTH-1:0];
      w_rem  = w_p_step[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_RUN;
               stall       = 1'b1;
            end
         end
         S_RUN: begin
            stall = 1'b1;
            if (r_cnt == LAST) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_p      <= '0;
         r_b_mag  <= '0;
         r_a_raw  <= '0;
         r_div    <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_cnt    <= '0;
            r_p      <= {{(WIDTH+1){1'b0}}, w_a_mag};
            r_b_mag  <= w_b_mag;
            r_a_raw  <= src_a;
            r_div    <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (src_b == '0);
         end else if (r_state == S_RUN) begin
            r_p   <= w_p_step;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               if (r_div && r_b_zero) begin
                  hi <= r_a_raw;
                  lo <= '1;
               end else if (r_div) begin
                  hi <= r_neg_r ? -w_rem : w_rem;
                  lo <= r_neg_q ? -w_quo : w_quo;
               end else begin
                  {hi, lo} <= w_prod;
               end
            end
         end
      end
   end
endmodule
